// File: rtl/uart_pkg.sv
// Shared UART definitions: frame-controller state encoding, default sync byte
// and the receive-timeout derivation reused by TX-side blocks.
package uart_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ADDR  = 3'd1;
  localparam logic [2:0] ST_LEN   = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_CHK   = 3'd4;
  localparam logic [2:0] ST_FLUSH = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_ADDR  = ST_ADDR,
    S_LEN   = ST_LEN,
    S_DATA  = ST_DATA,
    S_CHK   = ST_CHK,
    S_FLUSH = ST_FLUSH
  } frame_state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Two byte times of 10 bits each (start + 8 data + stop).
  function automatic int unsigned timeout_clks(input int unsigned clk_rate,
                                               input int unsigned baud_rate);
    return 20 * (clk_rate / baud_rate);
  endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload register file: one synchronous write port, one combinational read port.
// Contents are never cleared; only entries written for the current frame are read.
module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [7:0]    wd,
  input  logic [AW-1:0] ra,
  output logic [7:0]    rd
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  assign rd = mem[ra];

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Parses SYNC/ADDR/LEN/DATA/CHK frames from the UART byte stream, buffers the
// payload and replays it as register writes only once the XOR checksum matches.
import uart_pkg::*;

module uart_rx_frame_ctrl #(
  parameter int unsigned CLK_RATE    = 100000000,
  parameter int unsigned BAUD_RATE   = 115200,
  parameter int unsigned WORD_LENGTH = 8,
  parameter int unsigned MAX_PAYLOAD = 16,
  parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEFAULT
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_rx_valid,
  input  logic [WORD_LENGTH-1:0] i_rx_byte,
  output logic                   o_wr_en,
  output logic [7:0]             o_wr_addr,
  output logic [7:0]             o_wr_data,
  output logic                   o_frame_ok,
  output logic                   o_frame_err,
  output logic                   o_overrun,
  output logic                   o_busy,
  output logic [2:0]             o_state
);

  localparam int unsigned TIMEOUT_CLKS = timeout_clks(CLK_RATE, BAUD_RATE);
  localparam int          TW  = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam int          AW  = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CLKS - 1);
  localparam logic [7:0]    MAX_LEN = 8'(MAX_PAYLOAD);

  frame_state_t state_q, state_d;
  logic [7:0]    addr_q, addr_d, len_q, len_d, chk_q, chk_d, idx_q, idx_d;
  logic [TW-1:0] to_q, to_d;
  logic          wr_en_d, ok_d, err_d, ovr_d;
  logic [7:0]    wr_addr_d, wr_data_d;
  logic          buf_we, timed, timeout_hit;
  logic [7:0]    buf_rd;

  uart_frame_buf #(.DEPTH(MAX_PAYLOAD), .AW(AW)) u_buf (
    .clk (i_clk),
    .we  (buf_we),
    .wa  (idx_q[AW-1:0]),
    .wd  (i_rx_byte),
    .ra  (idx_q[AW-1:0]),
    .rd  (buf_rd)
  );

  assign timed = (state_q == S_ADDR) || (state_q == S_LEN) ||
                 (state_q == S_DATA) || (state_q == S_CHK);
  // An arriving byte always beats timeout expiry in the same cycle.
  assign timeout_hit = timed && !i_rx_valid && (to_q == TO_LAST);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    chk_d     = chk_q;
    idx_d     = idx_q;
    to_d      = '0;
    wr_en_d   = 1'b0;
    wr_addr_d = 8'h00;
    wr_data_d = 8'h00;
    ok_d      = 1'b0;
    err_d     = 1'b0;
    ovr_d     = 1'b0;
    buf_we    = 1'b0;
    if (timed && !i_rx_valid && !timeout_hit) to_d = to_q + TW'(1);
    unique case (state_q)
      S_IDLE: if (i_rx_valid && i_rx_byte == SYNC_BYTE) state_d = S_ADDR;
      S_ADDR: if (i_rx_valid) begin
        addr_d  = i_rx_byte;
        chk_d   = i_rx_byte;
        state_d = S_LEN;
      end
      S_LEN: if (i_rx_valid) begin
        if (i_rx_byte == 8'h00 || i_rx_byte > MAX_LEN) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          len_d   = i_rx_byte;
          chk_d   = chk_q ^ i_rx_byte;
          idx_d   = 8'h00;
          state_d = S_DATA;
        end
      end
      S_DATA: if (i_rx_valid) begin
        buf_we = 1'b1;
        chk_d  = chk_q ^ i_rx_byte;
        if (idx_q == len_q - 8'd1) begin
          idx_d   = 8'h00;
          state_d = S_CHK;
        end else begin
          idx_d = idx_q + 8'd1;
        end
      end
      // The first write leaves on the same edge the checksum is accepted.
      S_CHK: if (i_rx_valid) begin
        if (i_rx_byte == chk_q) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = buf_rd;
          idx_d     = 8'd1;
          state_d   = S_FLUSH;
        end else begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_FLUSH: begin
        ovr_d = i_rx_valid;
        if (idx_q == len_q) begin
          ok_d    = 1'b1;
          state_d = S_IDLE;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q + idx_q;
          wr_data_d = buf_rd;
          idx_d     = idx_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (timeout_hit) begin
      err_d   = 1'b1;
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      chk_q       <= '0;
      idx_q       <= '0;
      to_q        <= '0;
      o_wr_en     <= 1'b0;
      o_wr_addr   <= '0;
      o_wr_data   <= '0;
      o_frame_ok  <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      chk_q       <= chk_d;
      idx_q       <= idx_d;
      to_q        <= to_d;
      o_wr_en     <= wr_en_d;
      o_wr_addr   <= wr_addr_d;
      o_wr_data   <= wr_data_d;
      o_frame_ok  <= ok_d;
      o_frame_err <= err_d;
      o_overrun   <= ovr_d;
      o_busy      <= (state_d != S_IDLE);
    end
  end

  assign o_state = state_q;

endmodule
